// File: rtl/uart_cmd_parser.sv
// UART command parser: collects 0x5A-framed read/write commands from a byte stream,
// performs the SRAM accesses they describe and returns a status or read-data bytes.
module uart_cmd_parser #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int MAX_LEN     = 16
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic [7:0]  i_uart_data,
  input  logic        i_uart_valid,
  output logic [7:0]  o_uart_data,
  output logic        o_uart_valid,
  input  logic        i_uart_tx_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_busy,
  output logic [3:0]  o_dbg_state
);

  // Handshakes: a response byte transfers on a cycle with o_uart_valid && i_uart_tx_ready;
  // o_uart_valid/o_uart_data stay stable until then. o_mem_req and its address/data stay
  // stable until the one-cycle i_mem_ack. i_uart_valid is a one-cycle strobe, no backpressure.

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CMD    = 4'd1,
    S_ADDR_H = 4'd2,
    S_ADDR_L = 4'd3,
    S_LEN    = 4'd4,
    S_DATA   = 4'd5,
    S_CSUM   = 4'd6,
    S_MEM_WR = 4'd7,
    S_MEM_RD = 4'd8,
    S_RESP   = 4'd9
  } state_t;

  localparam int              GW        = $clog2(TIMEOUT_CYC + 1);
  localparam int              IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [GW-1:0]   GAP_LAST  = GW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0]      SOF       = 8'h5A;
  localparam logic [7:0]      CMD_WR    = 8'h01;
  localparam logic [7:0]      CMD_RD    = 8'h02;
  localparam logic [7:0]      RSP_OK    = 8'hA5;
  localparam logic [7:0]      RSP_ERR   = 8'hEE;

  state_t        r_state;
  logic [7:0]    r_cmd;
  logic [15:0]   r_addr;
  logic [7:0]    r_len;
  logic [7:0]    r_csum;
  logic [7:0]    r_idx;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_buf [0:MAX_LEN-1];

  logic [7:0]    r_uart_data;
  logic          r_uart_valid;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [15:0]   r_mem_addr;
  logic [7:0]    r_mem_wdata;

  logic          w_in_frame;
  logic          w_frame_ok;
  logic          w_tx_acc;
  logic          w_buf_we;
  logic [7:0]    w_idx_nxt;

  assign w_in_frame = (r_state inside {S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_DATA, S_CSUM});
  assign w_tx_acc   = r_uart_valid && i_uart_tx_ready;
  assign w_idx_nxt  = r_idx + 8'd1;
  // Evaluated while the CSUM byte is on i_uart_data: checksum, command and length all legal.
  assign w_frame_ok = (i_uart_data == r_csum) &&
                      ((r_cmd == CMD_WR) || (r_cmd == CMD_RD)) &&
                      (r_len != 8'd0) && (r_len <= MAX_LEN_B);
  // Over-length payloads are still consumed for the checksum but never stored.
  assign w_buf_we   = (r_state == S_DATA) && i_uart_valid && (r_idx < MAX_LEN_B);

  always_ff @(posedge i_clk_sys) begin
    if (w_buf_we) begin
      r_buf[r_idx[IW-1:0]] <= i_uart_data;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_cmd        <= '0;
      r_addr       <= '0;
      r_len        <= '0;
      r_csum       <= '0;
      r_idx        <= '0;
      r_gap        <= '0;
      r_uart_data  <= '0;
      r_uart_valid <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      if (w_in_frame && !i_uart_valid) begin
        if (r_gap == GAP_LAST) begin
          r_state <= S_IDLE;
          r_gap   <= '0;
        end else begin
          r_gap <= r_gap + GW'(1);
        end
      end else begin
        r_gap <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_uart_valid && (i_uart_data == SOF)) r_state <= S_CMD;
        end
        S_CMD: begin
          if (i_uart_valid) begin
            r_cmd   <= i_uart_data;
            r_csum  <= i_uart_data;
            r_state <= S_ADDR_H;
          end
        end
        S_ADDR_H: begin
          if (i_uart_valid) begin
            r_addr[15:8] <= i_uart_data;
            r_csum       <= r_csum ^ i_uart_data;
            r_state      <= S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          if (i_uart_valid) begin
            r_addr[7:0] <= i_uart_data;
            r_csum      <= r_csum ^ i_uart_data;
            r_state     <= S_LEN;
          end
        end
        S_LEN: begin
          if (i_uart_valid) begin
            r_len  <= i_uart_data;
            r_csum <= r_csum ^ i_uart_data;
            r_idx  <= '0;
            // Only a write with a non-zero length carries payload bytes.
            r_state <= ((r_cmd == CMD_WR) && (i_uart_data != 8'd0)) ? S_DATA : S_CSUM;
          end
        end
        S_DATA: begin
          if (i_uart_valid) begin
            r_csum <= r_csum ^ i_uart_data;
            r_idx  <= w_idx_nxt;
            if (w_idx_nxt == r_len) r_state <= S_CSUM;
          end
        end
        S_CSUM: begin
          if (i_uart_valid) begin
            r_idx <= '0;
            if (!w_frame_ok) begin
              r_uart_data  <= RSP_ERR;
              r_uart_valid <= 1'b1;
              r_state      <= S_RESP;
            end else if (r_cmd == CMD_WR) begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= r_buf[0];
              r_state     <= S_MEM_WR;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_addr;
              r_state    <= S_MEM_RD;
            end
          end
        end
        S_MEM_WR: begin
          if (r_mem_req && i_mem_ack) begin
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == r_len) begin
              r_mem_req    <= 1'b0;
              r_mem_we     <= 1'b0;
              r_uart_data  <= RSP_OK;
              r_uart_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_mem_addr  <= r_mem_addr + 16'd1;
              r_mem_wdata <= r_buf[w_idx_nxt[IW-1:0]];
            end
          end
        end
        S_MEM_RD: begin
          // Alternates between one outstanding read and one pending response byte.
          if (r_mem_req && i_mem_ack) begin
            r_mem_req    <= 1'b0;
            r_uart_data  <= i_mem_rdata;
            r_uart_valid <= 1'b1;
            r_idx        <= w_idx_nxt;
          end else if (w_tx_acc) begin
            r_uart_valid <= 1'b0;
            if (r_idx == r_len) begin
              r_state <= S_IDLE;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_mem_addr + 16'd1;
            end
          end
        end
        S_RESP: begin
          if (w_tx_acc) begin
            r_uart_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_uart_data  = r_uart_data;
  assign o_uart_valid = r_uart_valid;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = (r_state != S_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: frames are built from field values, expected SRAM accesses and
// response bytes come from a frame-level model, and a responder/monitor records the DUT side.
module tb_uart_cmd_parser;

  localparam int TO = 40;
  localparam int ML = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [3:0]  dbg_state;

  always #5 clk = ~clk;

  uart_cmd_parser #(.TIMEOUT_CYC(TO), .MAX_LEN(ML)) dut (
    .i_clk_sys       (clk),
    .i_rst_n         (rst_n),
    .i_uart_data     (uart_data),
    .i_uart_valid    (uart_valid),
    .o_uart_data     (tx_data),
    .o_uart_valid    (tx_valid),
    .i_uart_tx_ready (tx_ready),
    .o_mem_req       (mem_req),
    .o_mem_we        (mem_we),
    .o_mem_addr      (mem_addr),
    .o_mem_wdata     (mem_wdata),
    .i_mem_ack       (mem_ack),
    .i_mem_rdata     (mem_rdata),
    .o_busy          (busy),
    .o_dbg_state     (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_overlap = 0;

  logic [7:0]  sram    [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  logic [7:0]  exp_tx_q[$];
  logic [7:0]  obs_tx_q[$];
  logic [7:0]  g_pay[$];
  logic [7:0]  g_pre[$];

  int lat_min = 1;
  int lat_max = 1;
  int ready_mode = 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // SRAM responder: acks after a random latency, records every completed access.
  initial begin
    int wait_cnt;
    int cur_lat;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    wait_cnt = 0;
    cur_lat = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt == 0) cur_lat = $urandom_range(lat_min, lat_max);
        if (wait_cnt >= cur_lat) begin
          mem_ack = 1'b1;
          wait_cnt = 0;
          obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
          if (mem_we) sram[mem_addr] = mem_wdata;
          else mem_rdata = sram[mem_addr];
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: tx_ready = 1'b0;
        1: tx_ready = 1'b1;
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) obs_tx_q.push_back(tx_data);
      if (mem_req && tx_valid) n_overlap++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, got time %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Called #1 after a rising edge; returns #1 after the edge that sampled the byte.
  task automatic send_byte(input logic [7:0] b);
    uart_data = b;
    uart_valid = 1'b1;
    @(posedge clk); #1;
    uart_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Builds one frame from its fields, queues the expected results, and sends it.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [7:0] len,
                           input bit bad_csum, input bit junk, input int gmin, input int gmax);
    logic [7:0]  body[$];
    logic [7:0]  cs;
    logic [15:0] a;
    bit          ok;
    int          np;
    np = (cmd == 8'h01) ? int'(len) : 0;
    while (g_pay.size() < np) g_pay.push_back(8'($urandom));
    body.push_back(cmd);
    body.push_back(addr[15:8]);
    body.push_back(addr[7:0]);
    body.push_back(len);
    for (int i = 0; i < np; i++) body.push_back(g_pay[i]);
    cs = 8'h00;
    foreach (body[i]) cs ^= body[i];
    if (bad_csum) cs ^= 8'(1 << $urandom_range(0, 7));
    ok = !bad_csum && (cmd == 8'h01 || cmd == 8'h02) && len != 0 && len <= ML;
    if (!ok) begin
      exp_tx_q.push_back(8'hEE);
    end else if (cmd == 8'h01) begin
      for (int i = 0; i < len; i++) begin
        a = addr + 16'(i);
        exp_q.push_back({1'b1, a, g_pay[i]});
        ref_mem[a] = g_pay[i];
      end
      exp_tx_q.push_back(8'hA5);
    end else begin
      for (int i = 0; i < len; i++) begin
        a = addr + 16'(i);
        exp_q.push_back({1'b0, a, 8'h00});
        exp_tx_q.push_back(ref_mem[a]);
      end
    end
    foreach (g_pre[i]) begin
      send_byte(g_pre[i]);
      idle($urandom_range(0, 2));
    end
    send_byte(8'h5A);
    foreach (body[i]) begin
      idle($urandom_range(gmin, gmax));
      send_byte(body[i]);
    end
    idle($urandom_range(gmin, gmax));
    send_byte(cs);
    check("req_latency", 32'(mem_req), 32'(ok));
    check("err_latency", 32'(tx_valid), 32'(!ok));
    g_pay.delete();
    g_pre.delete();
    if (junk && ok) begin
      send_byte(8'h5A);
      send_byte(8'h02);
    end
  endtask

  task automatic finish_frame(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      idle(1);
      n++;
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
    check({tag, "_mem_cnt"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) check({tag, "_mem_op"}, obs_q.pop_front(), exp_q.pop_front());
    check({tag, "_tx_cnt"}, obs_tx_q.size(), exp_tx_q.size());
    while (exp_tx_q.size() > 0 && obs_tx_q.size() > 0) check({tag, "_tx_byte"}, obs_tx_q.pop_front(), exp_tx_q.pop_front());
    exp_q.delete();
    obs_q.delete();
    exp_tx_q.delete();
    obs_tx_q.delete();
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [7:0]  b;
    logic [7:0]  saved[3];
    logic [15:0] addr;
    int          r;
    int          n;

    for (int i = 0; i < 65536; i++) begin
      b = 8'($urandom);
      sram[i] = b;
      ref_mem[i] = b;
    end
    uart_data = 8'h00;
    uart_valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_tx_valid", 32'(tx_valid), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 0);
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Write two bytes at 0x1234, ack one cycle after each request.
    g_pay.push_back(8'hAA);
    g_pay.push_back(8'hBB);
    run_frame(8'h01, 16'h1234, 8'd2, 0, 0, 0, 0);
    finish_frame("wr");

    // Single read at 0x0010 returning 0x77.
    sram[16'h0010] = 8'h77;
    ref_mem[16'h0010] = 8'h77;
    run_frame(8'h02, 16'h0010, 8'd1, 0, 0, 0, 0);
    finish_frame("rd");

    // Bad checksum: error byte, no memory traffic.
    g_pay.push_back(8'h55);
    run_frame(8'h01, 16'h0000, 8'd1, 1, 0, 0, 0);
    finish_frame("badcs");

    // Abandoned frame after a full timeout, then a wrapping read.
    send_byte(8'h5A);
    send_byte(8'h01);
    idle(TO);
    check("timeout_busy", 32'(busy), 0);
    run_frame(8'h02, 16'hFFFF, 8'd2, 0, 0, 0, 2);
    finish_frame("wrap");

    // Gaps one short of the timeout keep the frame alive.
    run_frame(8'h02, 16'h0020, 8'd1, 0, 0, TO - 1, TO - 1);
    finish_frame("gap_edge");

    // Garbage before the start byte.
    g_pre.push_back(8'h00);
    g_pre.push_back(8'hFF);
    run_frame(8'h01, 16'h2000, 8'd2, 0, 0, 0, 1);
    finish_frame("garbage");

    // Zero length, over-length and unknown command are all answered with an error.
    run_frame(8'h01, 16'h3000, 8'd0, 0, 0, 0, 0);
    finish_frame("len0");
    run_frame(8'h01, 16'h3000, 8'(ML + 1), 0, 0, 0, 0);
    finish_frame("lenbig");
    run_frame(8'h07, 16'h3000, 8'd1, 0, 0, 0, 0);
    finish_frame("badcmd");

    // Transmitter backpressure during a read response.
    ready_mode = 0;
    run_frame(8'h02, 16'h0100, 8'd2, 0, 0, 0, 0);
    n = 0;
    while (!tx_valid && n < 100) begin
      idle(1);
      n++;
    end
    check("bp_valid", 32'(tx_valid), 1);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("bp_data", 32'(tx_data), 32'(ref_mem[16'h0100]));
      check("bp_hold", 32'(tx_valid), 1);
      check("bp_no_req", 32'(mem_req), 0);
    end
    ready_mode = 1;
    finish_frame("bp");

    // Reset while a write request is outstanding.
    lat_min = 8;
    lat_max = 8;
    for (int i = 0; i < 3; i++) saved[i] = ref_mem[16'h4000 + 16'(i)];
    run_frame(8'h01, 16'h4000, 8'd3, 0, 0, 0, 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 0);
    check("mid_rst_we", 32'(mem_we), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    check("mid_rst_tx", 32'(tx_valid), 0);
    idle(2);
    rst_n = 1'b1;
    check("mid_rst_no_ops", obs_q.size(), 0);
    for (int i = 0; i < 3; i++) ref_mem[16'h4000 + 16'(i)] = saved[i];
    exp_q.delete();
    exp_tx_q.delete();
    obs_q.delete();
    obs_tx_q.delete();
    lat_min = 1;
    lat_max = 1;
    run_frame(8'h01, 16'h4000, 8'd3, 0, 0, 0, 0);
    finish_frame("post_rst_wr");
    run_frame(8'h02, 16'h4000, 8'd3, 0, 0, 0, 0);
    finish_frame("post_rst_rd");

    // Randomized frames with random latency, backpressure, gaps and dropped bytes.
    lat_min = 0;
    lat_max = 3;
    ready_mode = 2;
    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? 8'h01 : (r < 8) ? 8'h02 : (r == 8) ? 8'h00 : 8'($urandom_range(3, 255));
      r = $urandom_range(0, 9);
      len = (r == 0) ? 8'd0 : (r == 1) ? 8'(ML + $urandom_range(1, 3)) : 8'($urandom_range(1, ML));
      addr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) addr = 16'hFFFF - 16'($urandom_range(0, 3));
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        do b = 8'($urandom); while (b == 8'h5A);
        g_pre.push_back(b);
      end
      run_frame(cmd, addr, len, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), 0, 3);
      finish_frame("rand");
    end

    check("req_tx_overlap", n_overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
